// File: rtl/uart_buf_pkg.sv
// Shared state encodings and default geometry for the UART buffer reader/writer.
package uart_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5,
    ST_CKSUM   = 3'd6
  } buf_state_e;

  localparam int UART_BUF_ADDR_W    = 16;
  localparam int UART_BUF_NUM_BYTES = 65536;

endpackage

// File: rtl/byte_xor_acc.sv
// Running 8-bit XOR of the bytes in a frame; used only when
// UART_READER_CHECKSUM_EN is defined.
module byte_xor_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  logic [7:0] acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     acc_q <= '0;
    else if (clear) acc_q <= '0;
    else if (en)    acc_q <= acc_q ^ din;
  end

  assign acc = acc_q;

endmodule

// File: rtl/uart_data_reader.sv
// Streams RAM bytes 0..NUM_BYTES-1 to the UART Tx core, one byte in flight.
// UART_READER_CHECKSUM_EN: appends an XOR checksum byte to each frame.
module uart_data_reader
  import uart_buf_pkg::*;
#(
  parameter int ADDR_W    = UART_BUF_ADDR_W,
  parameter int NUM_BYTES = UART_BUF_NUM_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] Addr,
  output logic              Ren,
  input  logic [7:0]        Din,
  output logic [7:0]        Dout,
  output logic              Tx_start,
  input  logic              Tx_busy,
  input  logic              Tx_done,
  output logic              fin
);

  // One extra bit so a full 2**ADDR_W frame count never wraps.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  buf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ren_q, ren_d;
  logic [7:0]        dout_q, dout_d;
  logic              tx_start_q, tx_start_d;
  logic              fin_q, fin_d;

`ifdef UART_READER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(NUM_BYTES);
  logic       acc_clr, acc_en;
  logic [7:0] acc;

  byte_xor_acc u_xor (
    .clk  (clk),
    .reset(reset),
    .clear(acc_clr),
    .en   (acc_en),
    .din  (Din),
    .acc  (acc)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      ren_q      <= 1'b0;
      dout_q     <= '0;
      tx_start_q <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ren_q      <= ren_d;
      dout_q     <= dout_d;
      tx_start_q <= tx_start_d;
      fin_q      <= fin_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ren_d      = 1'b0;
    dout_d     = dout_q;
    tx_start_d = 1'b0;
    fin_d      = fin_q;
`ifdef UART_READER_CHECKSUM_EN
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          cnt_d   = '0;
          fin_d   = 1'b0;
          ren_d   = 1'b1;
`ifdef UART_READER_CHECKSUM_EN
          acc_clr = 1'b1;
`endif
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        dout_d  = Din;
        state_d = ST_SEND;
`ifdef UART_READER_CHECKSUM_EN
        acc_en  = 1'b1;
`endif
      end
      ST_SEND: begin
        if (!Tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        // Address stops at the last byte; DONE parks it back at 0.
        if (Tx_done) begin
`ifdef UART_READER_CHECKSUM_EN
          if (cnt_q == FRAME_CNT) begin
            state_d = ST_DONE;
            fin_d   = 1'b1;
            addr_d  = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d = ST_CKSUM;
            cnt_d   = cnt_q + 1'b1;
          end
`else
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            fin_d   = 1'b1;
            addr_d  = '0;
            cnt_d   = cnt_q + 1'b1;
          end
`endif
          else begin
            state_d = ST_FETCH;
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            ren_d   = 1'b1;
          end
        end
      end
`ifdef UART_READER_CHECKSUM_EN
      ST_CKSUM: begin
        dout_d  = acc;
        state_d = ST_SEND;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign Addr     = addr_q;
  assign Ren      = ren_q;
  assign Dout     = dout_q;
  assign Tx_start = tx_start_q;
  assign fin      = fin_q;

endmodule

// File: tb/tb_uart_data_reader.sv
// Randomized scoreboard bench for uart_data_reader with RAM and Tx-core models.
module tb_uart_data_reader;

  localparam int AW = 4;
  localparam int NB = 16;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [AW-1:0] Addr;
  logic          Ren, Tx_start, Tx_busy, fin;
  logic [7:0]    Din = 8'h00, Dout;
  logic          Tx_done = 1'b0, busy_m = 1'b0, stuck = 1'b0;

  assign Tx_busy = busy_m | stuck;
  always #5 clk = ~clk;

  uart_data_reader #(.ADDR_W(AW), .NUM_BYTES(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .Addr(Addr), .Ren(Ren),
    .Din(Din), .Dout(Dout), .Tx_start(Tx_start), .Tx_busy(Tx_busy),
    .Tx_done(Tx_done), .fin(fin)
  );

  logic [7:0] mem [NB];
  always @(posedge clk) if (Ren) Din <= mem[Addr];

  // Tx core: busy for a random number of cycles, then a one-cycle done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (Tx_start === 1'b1) begin
        busy_m = 1'b1;
        repeat ($urandom_range(1, 12)) @(negedge clk);
        busy_m  = 1'b0;
        Tx_done = 1'b1;
        @(negedge clk);
        Tx_done = 1'b0;
      end
    end
  end

  int n_vec = 0, n_err = 0, tx_seen = 0;
  logic [7:0] exp_q [$];
  int         addr_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read request and every Tx_start consumes one expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (Ren === 1'b1) begin
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_ren: Addr %0d, no read expected at %0t", Addr, $time);
        end else check("read_addr", Addr, addr_q.pop_front());
      end
      if (Tx_start === 1'b1) begin
        tx_seen++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_tx_start: Dout %0h, no byte expected at %0t", Dout, $time);
        end else check("tx_byte", Dout, exp_q.pop_front());
      end
    end
  end

  // Reference frame: bytes in address order, optional XOR trailer.
  task automatic expect_frame();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(mem[i]);
      addr_q.push_back(i);
      x ^= mem[i];
    end
`ifdef UART_READER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
  endtask

  task automatic pulse_start(input bit chk_lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chk_lat) begin
      check("lat_ren_n1", Ren, 1);
      check("lat_txs_n1", Tx_start, 0);
      @(negedge clk); check("lat_txs_n2", Tx_start, 0);
      @(negedge clk); check("lat_txs_n3", Tx_start, 0);
      @(negedge clk); check("lat_txs_n4", Tx_start, 1);
    end
  endtask

  task automatic finish_frame(input bit spurious);
    int c;
    c = 0;
    while (fin !== 1'b1 && c < 4000) begin
      @(negedge clk);
      c++;
      start = spurious && (fin !== 1'b1) && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    check("fin_set", fin, 1);
    check("done_addr", Addr, 0);
    check("done_ren", Ren, 0);
    check("bytes_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
  endtask

  task automatic wait_tx_idle();
    int c;
    c = 0;
    while ((Tx_busy || Tx_done) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("tx_idle", Tx_busy | Tx_done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, Addr, 0);
    check({tag, "_ren"}, Ren, 0);
    check({tag, "_dout"}, Dout, 0);
    check({tag, "_txs"}, Tx_start, 0);
    check({tag, "_fin"}, fin, 0);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);

    // Known pattern at the head of the first frame, launch latency checked.
    fill_random();
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
    expect_frame();
    pulse_start(1'b1);
    finish_frame(1'b0);
    repeat (5) @(negedge clk);
    check("fin_hold", fin, 1);

    // Restart from DONE with ignored starts sprinkled through the frame.
    fill_random();
    expect_frame();
    pulse_start(1'b1);
    finish_frame(1'b1);

    // Tx core stuck busy: no launch while busy, launch right after release.
    fill_random();
    expect_frame();
    stuck = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("stuck_txs", Tx_start, 0);
      start = (i % 7 == 3);
    end
    start = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    check("release_txs", Tx_start, 1);
    finish_frame(1'b0);

    // Reset after the third byte has been launched.
    fill_random();
    expect_frame();
    base = tx_seen;
    pulse_start(1'b0);
    for (int c = 0; c < 500 && tx_seen < base + 3; c++) @(negedge clk);
    check("third_byte_seen", tx_seen - base, 3);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_rst");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_tx_idle();
    @(negedge clk);
    fill_random();
    expect_frame();
    pulse_start(1'b1);
    finish_frame(1'b1);

    for (int f = 0; f < 3; f++) begin
      fill_random();
      expect_frame();
      pulse_start(1'b1);
      finish_frame(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
